hazard_ctrl_mc: RTL and testbench

//  Multi-cycle-aware hazard controller for the 5-stage RISC-V pipeline with cache.

---
 rtl/hazard_pkg.sv | 12 +
 rtl/hazard_sat_counter.sv | 14 +
 rtl/hazard_ctrl_mc.sv | 143 ++++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and encodings for the multi-cycle hazard controller.
package hazard_pkg;
  typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT, MDU_BUSY} hz_state_t;

  localparam logic [2:0] RESULTSRC_LOAD = 3'b001;
  localparam logic [1:0] PCSRC_BR       = 2'b01;
  localparam logic [1:0] PCSRC_JALR     = 2'b10;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;
endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        count <= '0;
    else if (inc && (count != '1))  count <= count + CNT_WIDTH'(1);
  end
endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage pipeline: forwarding, load-use, branch flush,
// cache-miss freeze, multi-cycle MDU occupancy of EX, and perf counters.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int REG_FILE_ADDR_WIDTH = 5,
  parameter int MDU_LATENCY         = 4,
  parameter int CNT_WIDTH           = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           trigger,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] rs1d,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] rs2d,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] rs1e,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] rs2e,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] rde,
  input  logic [2:0]                     resultsrce,
  input  logic [1:0]                     pcsrce,
  input  logic                           muldive,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] rdm,
  input  logic                           regwritem,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] rdw,
  input  logic                           regwritew,
  input  logic                           cache_missm,
  input  logic                           cache_readym,
  output logic [1:0]                     forwardae,
  output logic [1:0]                     forwardbe,
  output logic                           stallf,
  output logic                           stalld,
  output logic                           stalle,
  output logic                           stallm,
  output logic                           flushd,
  output logic                           flushe,
  output logic                           flushm,
  output logic                           flushw,
  output logic                           mdu_busy,
  output logic [CNT_WIDTH-1:0]           stall_cnt,
  output logic [CNT_WIDTH-1:0]           flush_cnt
);
  localparam int AW = REG_FILE_ADDR_WIDTH;
  localparam int CW = $clog2(MDU_LATENCY);

  hz_state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0][AW-1:0] rse;
  logic [1:0][1:0] fwd;
  logic loaduse, redirect;
  logic idle, freeze_mem, freeze_mdu, eval_hz;

  assign rse = {rs2e, rs1e};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fwd[i] = FWD_NONE;
      if (rse[i] != '0) begin
        if (regwritem && (rdm == rse[i]))      fwd[i] = FWD_M;
        else if (regwritew && (rdw == rse[i])) fwd[i] = FWD_W;
      end
    end
    loaduse  = (resultsrce == RESULTSRC_LOAD) && (rde != '0) &&
               ((rde == rs1d) || (rde == rs2d));
    redirect = (pcsrce == PCSRC_BR) || (pcsrce == PCSRC_JALR);
  end

  assign forwardae = fwd[0];
  assign forwardbe = fwd[1];

  // A miss release re-evaluates EX fully (a mul/div may have been waiting behind
  // the miss); an MDU release only evaluates load-use/branch since muldive still
  // flags the op that is leaving EX.
  always_comb begin
    state_nxt  = state;
    idle       = 1'b0;
    freeze_mem = 1'b0;
    freeze_mdu = 1'b0;
    eval_hz    = 1'b0;
    unique case (state)
      IDLE: begin
        idle = 1'b1;
        if (trigger) state_nxt = RUN;
      end
      RUN, MEM_WAIT: begin
        if ((state == MEM_WAIT && !cache_readym) ||
            (state == RUN && cache_missm && !cache_readym)) begin
          freeze_mem = 1'b1;
          state_nxt  = MEM_WAIT;
        end else if (muldive) begin
          freeze_mdu = 1'b1;
          state_nxt  = MDU_BUSY;
        end else begin
          eval_hz    = 1'b1;
          state_nxt  = RUN;
        end
      end
      MDU_BUSY: begin
        if (cnt != '0) freeze_mdu = 1'b1;
        else begin
          eval_hz   = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stallf   = idle | freeze_mem | freeze_mdu | (eval_hz & loaduse);
  assign stalld   = stallf;
  assign stalle   = freeze_mem | freeze_mdu;
  assign stallm   = freeze_mem;
  assign flushw   = freeze_mem;
  assign flushm   = freeze_mdu;
  assign flushe   = eval_hz & (loaduse | redirect);
  assign flushd   = eval_hz & ~loaduse & redirect;
  assign mdu_busy = (state == MDU_BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (freeze_mdu && (state != MDU_BUSY)) cnt <= CW'(MDU_LATENCY - 2);
      else if ((state == MDU_BUSY) && (cnt != '0)) cnt <= cnt - CW'(1);
    end
  end

  logic [1:0] cnt_inc;
  logic [1:0][CNT_WIDTH-1:0] cnt_val;

  assign cnt_inc   = {flushd, stallf & ~idle};
  assign stall_cnt = cnt_val[0];
  assign flush_cnt = cnt_val[1];

  for (genvar g = 0; g < 2; g++) begin : g_cnt
    hazard_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (cnt_inc[g]),
      .count (cnt_val[g])
    );
  end
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: directed vectors with literal expectations plus a
// cycle-by-cycle occupancy model compared on every falling edge.
module tb_hazard_ctrl_mc;
  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, trigger, muldive, regwritem, regwritew, cache_missm, cache_readym;
  logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic [2:0] resultsrce;
  logic [1:0] pcsrce, forwardae, forwardbe;
  logic stallf, stalld, stalle, stallm, flushd, flushe, flushm, flushw, mdu_busy;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl_mc #(.REG_FILE_ADDR_WIDTH(AW), .MDU_LATENCY(LAT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .trigger(trigger),
    .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e), .rde(rde),
    .resultsrce(resultsrce), .pcsrce(pcsrce), .muldive(muldive),
    .rdm(rdm), .regwritem(regwritem), .rdw(rdw), .regwritew(regwritew),
    .cache_missm(cache_missm), .cache_readym(cache_readym),
    .forwardae(forwardae), .forwardbe(forwardbe),
    .stallf(stallf), .stalld(stalld), .stalle(stalle), .stallm(stallm),
    .flushd(flushd), .flushe(flushe), .flushm(flushm), .flushw(flushw),
    .mdu_busy(mdu_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // started: out of IDLE; in_miss: waiting for miss data;
  // age: cycles the current mul/div op has already spent in EX (0 = none).
  bit m_started, m_inmiss, n_started, n_inmiss;
  int m_age, n_age, m_sc, m_fc;
  bit lu, br, fz_mem, fz_mdu, hz, e_busy;
  logic [12:0] e_vec, a_vec;

  function automatic logic [1:0] fwd_of(input logic [AW-1:0] r);
    if (r == 0) return 2'b00;
    if (regwritem && rdm == r) return 2'b10;
    if (regwritew && rdw == r) return 2'b01;
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_started = 0; m_inmiss = 0; m_age = 0; m_sc = 0; m_fc = 0;
    end
    lu = (resultsrce == 3'b001) && (rde != 0) && (rde == rs1d || rde == rs2d);
    br = (pcsrce == 2'b01) || (pcsrce == 2'b10);
    fz_mem = 0; fz_mdu = 0; hz = 0; e_busy = 0;
    n_started = m_started; n_inmiss = m_inmiss; n_age = m_age;
    if (!m_started) n_started = trigger;
    else if (m_age > 0) begin
      e_busy = 1;
      if (m_age < LAT - 1) begin fz_mdu = 1; n_age = m_age + 1; end
      else begin hz = 1; n_age = 0; end
    end else if (m_inmiss && !cache_readym) fz_mem = 1;
    else if (!m_inmiss && cache_missm && !cache_readym) begin fz_mem = 1; n_inmiss = 1; end
    else begin
      n_inmiss = 0;
      if (muldive) begin fz_mdu = 1; n_age = 1; end
      else hz = 1;
    end
    e_vec = {!m_started || fz_mem || fz_mdu || (hz && lu),
             !m_started || fz_mem || fz_mdu || (hz && lu),
             fz_mem || fz_mdu, fz_mem,
             hz && !lu && br, hz && (lu || br), fz_mdu, fz_mem, e_busy,
             fwd_of(rs1e), fwd_of(rs2e)};
    a_vec = {stallf, stalld, stalle, stallm, flushd, flushe, flushm, flushw,
             mdu_busy, forwardae, forwardbe};
    chk("model_ctrl", 32'(a_vec), 32'(e_vec));
    chk("model_stall_cnt", 32'(stall_cnt), 32'(m_sc));
    chk("model_flush_cnt", 32'(flush_cnt), 32'(m_fc));
    if (!rst) begin
      if (m_started && e_vec[12] && m_sc < SAT) m_sc++;
      if (e_vec[8] && m_fc < SAT) m_fc++;
      m_started = n_started; m_inmiss = n_inmiss; m_age = n_age;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
    resultsrce = 0; pcsrce = 0; muldive = 0; regwritem = 0; regwritew = 0;
    cache_missm = 0; cache_readym = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; trigger = 0; clr();
    tick(); tick(); #2;
    chk("rst_stallf", 32'(stallf), 1);
    chk("rst_stalld", 32'(stalld), 1);
    chk("rst_stalle", 32'(stalle), 0);
    chk("rst_flushd", 32'(flushd), 0);
    chk("rst_mdu_busy", 32'(mdu_busy), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    rst = 0;

    // idle hold, then start
    repeat (3) begin tick(); #2; chk("idle_stallf", 32'(stallf), 1); end
    tick(); trigger = 1; #2; chk("trig_cycle_stallf", 32'(stallf), 1);
    tick(); trigger = 0; #2;
    chk("run_stallf", 32'(stallf), 0);
    chk("run_stall_cnt", 32'(stall_cnt), 0);

    // forwarding
    tick(); rs1e = 5; rdm = 5; regwritem = 1; rdw = 5; regwritew = 1; #2;
    chk("fwd_m_wins", 32'(forwardae), 2);
    tick(); regwritem = 0; #2;
    chk("fwd_w", 32'(forwardae), 1);
    tick(); rs1e = 0; rdw = 0; regwritew = 1; rdm = 0; regwritem = 1; #2;
    chk("fwd_x0", 32'(forwardae), 0);
    tick(); clr(); rs2e = 9; rdw = 9; regwritew = 1; #2;
    chk("fwd_b_w", 32'(forwardbe), 1);

    // load-use
    tick(); clr(); resultsrce = 3'b001; rde = 7; rs2d = 7; #2;
    chk("lu_stallf", 32'(stallf), 1);
    chk("lu_flushe", 32'(flushe), 1);
    chk("lu_stalle", 32'(stalle), 0);
    tick(); clr(); #2;
    chk("lu_release", 32'(stallf), 0);
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
    tick(); resultsrce = 3'b001; rde = 0; rs2d = 0; #2;
    chk("lu_x0_nostall", 32'(stallf), 0);

    // cache miss t0..t3, data at t4
    tick(); clr(); cache_missm = 1; #2;
    chk("miss_t0_stallm", 32'(stallm), 1);
    chk("miss_t0_flushw", 32'(flushw), 1);
    tick(); #2; chk("miss_t1_stalle", 32'(stalle), 1);
    tick(); cache_missm = 0; #2; chk("miss_t2_stallf", 32'(stallf), 1);
    tick(); #2; chk("miss_t3_flushw", 32'(flushw), 1);
    tick(); cache_missm = 1; cache_readym = 1; #2;
    chk("miss_t4_stallf", 32'(stallf), 0);
    chk("miss_t4_flushw", 32'(flushw), 0);
    tick(); clr(); #2;
    chk("miss_stall_cnt", 32'(stall_cnt), 5);

    // mul/div with branch deferred to release
    tick(); muldive = 1; #2;
    chk("mdu_a_stalle", 32'(stalle), 1);
    chk("mdu_a_flushm", 32'(flushm), 1);
    chk("mdu_a_busy", 32'(mdu_busy), 0);
    tick(); pcsrce = 2'b01; #2;
    chk("mdu_b_busy", 32'(mdu_busy), 1);
    chk("mdu_b_flushd", 32'(flushd), 0);
    tick(); #2;
    chk("mdu_c_stallf", 32'(stallf), 1);
    chk("mdu_c_flushd", 32'(flushd), 0);
    tick(); #2;
    chk("mdu_d_stallf", 32'(stallf), 0);
    chk("mdu_d_busy", 32'(mdu_busy), 1);
    chk("mdu_d_flushd", 32'(flushd), 1);
    chk("mdu_d_flushe", 32'(flushe), 1);
    tick(); clr(); #2;
    chk("mdu_e_busy", 32'(mdu_busy), 0);
    chk("mdu_stall_cnt", 32'(stall_cnt), 8);
    chk("mdu_flush_cnt", 32'(flush_cnt), 1);

    // reset in the middle of a miss
    tick(); cache_missm = 1;
    tick(); #2; chk("memwait_stalle", 32'(stalle), 1);
    rst = 1; #1;
    chk("midrst_stallf", 32'(stallf), 1);
    chk("midrst_stalle", 32'(stalle), 0);
    chk("midrst_stallm", 32'(stallm), 0);
    chk("midrst_flushw", 32'(flushw), 0);
    chk("midrst_stall_cnt", 32'(stall_cnt), 0);
    chk("midrst_flush_cnt", 32'(flush_cnt), 0);
    tick(); rst = 0; clr(); #2;
    chk("postrst_idle", 32'(stalld), 1);

    // saturation at 15
    tick(); trigger = 1;
    tick(); trigger = 0; resultsrce = 3'b001; rde = 3; rs1d = 3;
    repeat (19) tick();
    tick(); clr(); #2;
    chk("sat_stall_cnt", 32'(stall_cnt), 15);
    pcsrce = 2'b10;
    repeat (19) tick();
    tick(); clr(); #2;
    chk("sat_flush_cnt", 32'(flush_cnt), 15);

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
